// File: rtl/cfu_conv_pkg.sv
// rtl/cfu_conv_pkg.sv - shared command codes, FSM states and arithmetic helpers for the conv CFU
package cfu_conv_pkg;

  localparam logic [6:0] GRP_CTRL = 7'd0;
  localparam logic [6:0] GRP_FILT = 7'd1;
  localparam logic [6:0] GRP_WIN  = 7'd2;
  localparam logic [6:0] GRP_ACC  = 7'd3;

  localparam logic [2:0] OP_CTRL_INFO     = 3'd0;
  localparam logic [2:0] OP_CTRL_CFG      = 3'd1;
  localparam logic [2:0] OP_CTRL_CLEAR    = 3'd2;
  localparam logic [2:0] OP_CTRL_STATUS   = 3'd3;
  localparam logic [2:0] OP_LOAD          = 3'd0;
  localparam logic [2:0] OP_WIN_SHIFT_MAC = 3'd1;
  localparam logic [2:0] OP_WIN_MAC       = 3'd2;
  localparam logic [2:0] OP_ACC_ADD       = 3'd0;
  localparam logic [2:0] OP_ACC_TAKE      = 3'd1;
  localparam logic [2:0] OP_ACC_READ      = 3'd2;

  typedef enum logic [2:0] {IDLE, MAC1, MAC2, ACC_RD, ACC_WR, CLEAR, RESP} state_t;

  // (sext10(x) + sext10(off)) * f; the true product always fits in 18 signed bits
  function automatic logic signed [17:0] lane_prod(input logic [7:0] x, input logic [7:0] f,
                                                   input logic [8:0] off);
    logic signed [17:0] a;
    logic signed [17:0] b;
    a = {{10{x[7]}}, x} + {{9{off[8]}}, off};
    b = {{10{f[7]}}, f};
    return a * b;
  endfunction

  function automatic logic [31:0] sext_acc(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] t;
    t = v << (32 - w);
    return t >>> (32 - w);
  endfunction

  // returns {clamped, value} with value limited to the signed w-bit range
  function automatic logic [32:0] clamp_acc(input logic signed [32:0] v, input int unsigned w);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (v > hi) return {1'b1, hi[31:0]};
    else if (v < lo) return {1'b1, lo[31:0]};
    else return {1'b0, v[31:0]};
  endfunction

endpackage

// File: rtl/cfu_mac_tree.sv
// rtl/cfu_mac_tree.sv - registered per-lane offset products followed by a combinational adder tree
module cfu_mac_tree
  import cfu_conv_pkg::*;
#(
  parameter int LANES = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [LANES*8-1:0] filt,
  input  logic [LANES*8-1:0] win,
  input  logic [8:0]         offset,
  output logic               valid,
  output logic [31:0]        sum
);
  logic signed [17:0] prod_q [LANES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < LANES; j++) prod_q[j] <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        for (int j = 0; j < LANES; j++) prod_q[j] <= lane_prod(win[8*j +: 8], filt[8*j +: 8], offset);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < LANES; j++) sum = sum + {{14{prod_q[j][17]}}, prod_q[j]};
  end

endmodule

// File: rtl/cfu_conv_mac.sv
// rtl/cfu_conv_mac.sv - convolution CFU: command decode, FSM, filter/window registers, accumulator RAM
module cfu_conv_mac
  import cfu_conv_pkg::*;
#(
  parameter int LANES      = 12,
  parameter int ROWS       = 28,
  parameter int COLS       = 28,
  parameter int ACC_W      = 32,
  parameter int OFFSET_RST = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);
  localparam int WORDS = LANES / 4;
  localparam int FW    = LANES * 8;
  localparam int WI    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

  state_t state, state_nx;
  logic [6:0] grp;
  logic [2:0] op;
  logic accept, word_ok, acc_in_range;
  logic [WI-1:0] widx;
  logic [AW-1:0] acc_addr, addr_q, clr_cnt_q, mem_addr;
  logic [FW-1:0] filt_q, win_q;
  logic [8:0] offset_q;
  logic sat_en_q, sat_seen_q, addr_err_q, acc_ok_q;
  logic [2:0] acc_op_q;
  logic [31:0] result_q, rsp_q;
  logic mem_we;
  logic [ACC_W-1:0] mem_wdata, mem_rdata;
  logic [ACC_W-1:0] mem [DEPTH];
  logic tree_en, tree_valid;
  logic [31:0] tree_sum, rd_ext, acc_old, wrap_val, acc_new;
  logic [32:0] sum33, clamp_r;

  assign grp          = cmd_payload_function_id[9:3];
  assign op           = cmd_payload_function_id[2:0];
  assign accept       = cmd_valid & cmd_ready;
  assign widx         = cmd_payload_inputs_1[WI-1:0];
  assign word_ok      = cmd_payload_inputs_1 < 32'(WORDS);
  assign acc_in_range = (cmd_payload_inputs_0 < 32'(ROWS)) && (cmd_payload_inputs_1 < 32'(COLS));
  assign acc_addr     = AW'(cmd_payload_inputs_0[RW-1:0]) * AW'(COLS) + AW'(cmd_payload_inputs_1[CW-1:0]);
  assign rsp_payload_outputs_0 = rsp_q;

  cfu_mac_tree #(.LANES(LANES)) u_tree (
    .clk   (clk),
    .reset (reset),
    .en    (tree_en),
    .filt  (filt_q),
    .win   (win_q),
    .offset(offset_q),
    .valid (tree_valid),
    .sum   (tree_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = RESP;
          if (grp == GRP_WIN && (op == OP_WIN_SHIFT_MAC || op == OP_WIN_MAC)) state_nx = MAC1;
          else if (grp == GRP_ACC && op <= OP_ACC_READ) state_nx = ACC_RD;
          else if (grp == GRP_CTRL && op == OP_CTRL_CLEAR) state_nx = CLEAR;
        end
      end
      MAC1:    state_nx = MAC2;
      MAC2:    state_nx = RESP;
      ACC_RD:  state_nx = ACC_WR;
      ACC_WR:  state_nx = RESP;
      CLEAR:   if (clr_cnt_q == AW'(DEPTH - 1)) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    tree_en   = (state == MAC1);
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = '0;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
    end else if (state == ACC_WR && acc_ok_q && acc_op_q != OP_ACC_READ) begin
      mem_we    = 1'b1;
      mem_wdata = (acc_op_q == OP_ACC_ADD) ? acc_new[ACC_W-1:0] : '0;
    end
  end

  // read-modify-write arithmetic: exact 33-bit sum, then wrap or clamp to ACC_W
  always_comb begin
    rd_ext = '0;
    rd_ext[ACC_W-1:0] = mem_rdata;
  end
  assign acc_old  = sext_acc(rd_ext, ACC_W);
  assign sum33    = {acc_old[31], acc_old} + {result_q[31], result_q};
  assign wrap_val = sext_acc(sum33[31:0], ACC_W);
  assign clamp_r  = clamp_acc(sum33, ACC_W);
  assign acc_new  = sat_en_q ? clamp_r[31:0] : wrap_val;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q     <= '0;
      win_q      <= '0;
      offset_q   <= 9'(OFFSET_RST);
      sat_en_q   <= 1'b0;
      sat_seen_q <= 1'b0;
      addr_err_q <= 1'b0;
      result_q   <= '0;
      rsp_q      <= '0;
      acc_op_q   <= '0;
      acc_ok_q   <= 1'b0;
      addr_q     <= '0;
      clr_cnt_q  <= '0;
    end else begin
      if (accept) begin
        rsp_q     <= '0;
        acc_op_q  <= op;
        acc_ok_q  <= acc_in_range;
        addr_q    <= acc_addr;
        clr_cnt_q <= '0;
        case (grp)
          GRP_CTRL: begin
            case (op)
              OP_CTRL_INFO: rsp_q <= {16'd0, 16'(LANES)};
              OP_CTRL_CFG: begin
                offset_q <= cmd_payload_inputs_0[8:0];
                sat_en_q <= cmd_payload_inputs_0[16];
              end
              OP_CTRL_CLEAR: begin
                filt_q <= '0;
                win_q  <= '0;
              end
              OP_CTRL_STATUS: begin
                rsp_q      <= {30'd0, sat_seen_q, addr_err_q};
                sat_seen_q <= 1'b0;
                addr_err_q <= 1'b0;
              end
              default: ;
            endcase
          end
          GRP_FILT: begin
            if (op == OP_LOAD) begin
              if (word_ok) filt_q[widx*32 +: 32] <= cmd_payload_inputs_0;
              else addr_err_q <= 1'b1;
            end
          end
          GRP_WIN: begin
            case (op)
              OP_LOAD: begin
                if (word_ok) win_q[widx*32 +: 32] <= cmd_payload_inputs_0;
                else addr_err_q <= 1'b1;
              end
              OP_WIN_SHIFT_MAC: win_q <= FW'({cmd_payload_inputs_0, win_q} >> 32);
              default: ;
            endcase
          end
          GRP_ACC: if (op <= OP_ACC_READ && !acc_in_range) addr_err_q <= 1'b1;
          default: ;
        endcase
      end
      if (state == MAC2 && tree_valid) begin
        result_q <= tree_sum;
        rsp_q    <= tree_sum;
      end
      if (state == ACC_WR) begin
        if (!acc_ok_q) rsp_q <= '0;
        else if (acc_op_q == OP_ACC_ADD) begin
          rsp_q <= acc_new;
          if (sat_en_q && clamp_r[32]) sat_seen_q <= 1'b1;
        end else rsp_q <= acc_old;
      end
      if (state == CLEAR) clr_cnt_q <= clr_cnt_q + AW'(1);
    end
  end

endmodule

// File: tb/tb_cfu_conv_mac.sv
// tb/tb_cfu_conv_mac.sv - scoreboard bench for cfu_conv_mac with a behavioural reference model
module tb_cfu_conv_mac;
  localparam int LANES = 12;
  localparam int ROWS  = 28;
  localparam int COLS  = 28;
  localparam int ACC_W = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  cfu_conv_mac #(.LANES(LANES), .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OFFSET_RST(128)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_payload_function_id(fid),
    .cmd_payload_inputs_0   (in0),
    .cmd_payload_inputs_1   (in1),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_payload_outputs_0  (rsp_data)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  int ready_mode = 0;

  int     filt_m [LANES];
  int     win_m [LANES];
  longint buf_m [ROWS][COLS];
  int     result_m, off_m;
  bit     sat_m, aerr_m, sseen_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic logic [9:0] F(input int g, input int o);
    return {7'(g), 3'(o)};
  endfunction

  function automatic int sbyte(input logic [31:0] w, input int k);
    logic [7:0] bv;
    bv = w[8*k +: 8];
    return $signed(bv);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      filt_m[i] = 0;
      win_m[i]  = 0;
    end
    result_m = 0;
    off_m    = 128;
    sat_m    = 0;
    aerr_m   = 0;
    sseen_m  = 0;
  endtask

  task automatic model_exec(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] e);
    int g, o, s;
    longint v, lim, m;
    logic [8:0] o9;
    g = f[9:3];
    o = f[2:0];
    e = '0;
    lim = longint'(1) << (ACC_W - 1);
    if (g == 0) begin
      if (o == 0) e = LANES;
      else if (o == 1) begin
        o9 = a[8:0];
        off_m = $signed(o9);
        sat_m = a[16];
      end else if (o == 2) begin
        for (int i = 0; i < LANES; i++) begin
          filt_m[i] = 0;
          win_m[i]  = 0;
        end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) buf_m[r][c] = 0;
      end else if (o == 3) begin
        e = {30'd0, sseen_m, aerr_m};
        sseen_m = 0;
        aerr_m = 0;
      end
    end else if ((g == 1 || g == 2) && o == 0) begin
      if (b < LANES / 4) begin
        for (int k = 0; k < 4; k++) begin
          if (g == 1) filt_m[4*b+k] = sbyte(a, k);
          else win_m[4*b+k] = sbyte(a, k);
        end
      end else aerr_m = 1;
    end else if (g == 2 && (o == 1 || o == 2)) begin
      if (o == 1) begin
        for (int j = 0; j < LANES - 4; j++) win_m[j] = win_m[j+4];
        for (int k = 0; k < 4; k++) win_m[LANES-4+k] = sbyte(a, k);
      end
      s = 0;
      for (int j = 0; j < LANES; j++) s += (win_m[j] + off_m) * filt_m[j];
      result_m = s;
      e = s;
    end else if (g == 3 && o <= 2) begin
      if (a >= ROWS || b >= COLS) aerr_m = 1;
      else begin
        v = buf_m[a][b];
        if (o == 0) begin
          v = v + result_m;
          if (sat_m) begin
            if (v > lim - 1) begin v = lim - 1; sseen_m = 1; end
            else if (v < -lim) begin v = -lim; sseen_m = 1; end
          end else begin
            m = (v + lim) % (2 * lim);
            if (m < 0) m += 2 * lim;
            v = m - lim;
          end
          buf_m[a][b] = v;
        end else if (o == 1) buf_m[a][b] = 0;
        e = 32'(v);
      end
    end
  endtask

  // issues one command, queues its expected response, returns once the DUT accepts it
  task automatic cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                     input bit use_k = 1'b0, input logic [31:0] k = '0);
    logic [31:0] e;
    int n;
    model_exec(f, a, b, e);
    exp_q.push_back(use_k ? k : e);
    fid = f;
    in0 = a;
    in1 = b;
    cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 3000);
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // monitor: randomised back-pressure, payload stability and scoreboard compare
  initial begin : monitor
    logic [31:0] held;
    bit held_ok;
    held_ok = 0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) rsp_ready = 1'b0;
      else if (ready_mode == 1) rsp_ready = 1'b1;
      else rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (rsp_valid) begin
        check("cmd_ready_during_rsp", {31'd0, cmd_ready}, 32'd0);
        if (held_ok) check("rsp_payload_stable", rsp_data, held);
        if (rsp_ready) begin
          held_ok = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: got 0x%08h, required no response", rsp_data);
          end else check("rsp_data", rsp_data, exp_q.pop_front());
        end else begin
          held_ok = 1;
          held = rsp_data;
        end
      end else held_ok = 0;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int g, o, n;
    logic [31:0] a, b;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_payload", rsp_data, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    cmd(F(0, 0), 0, 0, 1'b1, 32'd12);
    cmd(F(0, 3), 0, 0, 1'b1, 32'd0);
    cmd(F(0, 2), 0, 0);

    cmd(F(0, 2), 0, 0);
    repeat (200) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midclear_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midclear_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midclear_payload", rsp_data, 32'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cmd(F(0, 2), 0, 0);

    for (int i = 0; i < 3; i++) cmd(F(1, 0), 32'h0202_0202, i);
    for (int i = 0; i < 3; i++) cmd(F(2, 0), 32'h0101_0101, i);
    cmd(F(2, 2), 0, 0, 1'b1, 32'd3096);
    cmd(F(3, 0), 3, 5, 1'b1, 32'd3096);
    cmd(F(3, 0), 3, 5, 1'b1, 32'd6192);
    cmd(F(3, 1), 3, 5, 1'b1, 32'd6192);
    cmd(F(3, 2), 3, 5, 1'b1, 32'd0);
    cmd(F(3, 0), 27, 27, 1'b1, 32'd3096);
    cmd(F(3, 0), 28, 0, 1'b1, 32'd0);
    cmd(F(0, 3), 0, 0, 1'b1, 32'd1);
    cmd(F(0, 3), 0, 0, 1'b1, 32'd0);
    cmd(F(2, 1), 32'h7F7F_7F7F, 0, 1'b1, 32'd4104);

    for (int i = 0; i < 3; i++) cmd(F(2, 0), 32'h0101_0101, i);
    cmd(F(2, 2), 0, 0, 1'b1, 32'd3096);
    for (int i = 0; i < 170; i++) cmd(F(3, 0), 10, 10, (i == 169), -522256);
    cmd(F(0, 1), 32'h0001_0080, 0);
    for (int i = 0; i < 170; i++) cmd(F(3, 0), 11, 11, (i == 169), 32'd524287);
    cmd(F(0, 3), 0, 0, 1'b1, 32'd2);

    cmd(F(0, 1), 0, 0);
    for (int i = 0; i < 3; i++) cmd(F(2, 0), 32'hFFFF_FFFF, i);
    for (int i = 0; i < 3; i++) cmd(F(1, 0), 32'h0303_0303, i);
    @(negedge clk);
    ready_mode = 2;
    cmd(F(2, 2), 0, 0, 1'b1, -36);
    repeat (9) @(posedge clk);
    @(negedge clk);
    ready_mode = 0;

    for (int i = 0; i < 400; i++) begin
      g = $urandom_range(0, 4);
      o = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) o = $urandom_range(4, 7);
      if (g == 4) g = $urandom_range(4, 127);
      if (g == 0 && o == 2 && $urandom_range(0, 9) != 0) o = 0;
      a = $urandom;
      b = $urandom;
      if (g == 1 || g == 2) b = $urandom_range(0, 3);
      if (g == 3) begin
        a = $urandom_range(0, 29);
        b = $urandom_range(0, 29);
      end
      if (g == 0 && o == 1) a = a & 32'h0001_01FF;
      cmd(F(g, o), a, b);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
